// File: rtl/bcd_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_sub_serial
//  Purpose  : Digit-serial multi-digit BCD subtractor producing the
//             sign-magnitude result of x - y - b_in. One BCD digit is handled
//             per clock, least-significant digit first. A negative raw
//             difference is turned into its magnitude by a second serial
//             tens-complement pass over the partial result.
//  Ports    : clk    - rising-edge clock
//             rst_n  - synchronous reset, active low
//             start  - operation request, sampled only while idle
//             x, y   - minuend / subtrahend, BCD, digit 0 in bits [3:0]
//             b_in   - borrow in, for chaining wider subtractions
//             busy   - high while digits are being processed
//             done   - one-cycle pulse marking z/neg/err valid
//             z      - result magnitude, BCD
//             neg    - result of x - y - b_in is negative
//             err    - an input digit was outside 0..9
//  Revision : 1.0  initial release
// ============================================================================
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] x,
  input  logic [4*DIGITS-1:0] y,
  input  logic                b_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] z,
  output logic                neg,
  output logic                err
);

  localparam int             c_W    = 4 * DIGITS;
  localparam int             c_IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_W-1:0]  r_x;
  logic [c_W-1:0]  r_y;
  logic [c_W-1:0]  r_r;        // partial result, never visible on z
  logic [c_IW-1:0] r_idx;
  logic            r_borrow;
  logic            r_err_pend; // DONE entered from an invalid operand
  logic            r_busy;
  logic            r_done;
  logic [c_W-1:0]  r_z;
  logic            r_neg;
  logic            r_err;

  // --------------------------------------------------------------------------
  // Operand validity: any nibble of 10..15 is not a BCD digit.
  // --------------------------------------------------------------------------
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9) w_bad = 1'b1;
      if (y[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Shared single-digit subtract. In SUB it computes x_i - y_i - borrow; in
  // FIX the same cell computes 0 - r_i - borrow, which walks the tens
  // complement of the partial result across the digits.
  // --------------------------------------------------------------------------
  logic [3:0]     w_min;
  logic [3:0]     w_sub;
  logic [4:0]     w_d;
  logic [3:0]     w_digit;
  logic           w_bout;
  logic [c_W-1:0] w_r_next;

  always_comb begin
    w_min    = 4'd0;
    w_sub    = r_r[4*r_idx +: 4];
    if (r_state == S_SUB) begin
      w_min = r_x[4*r_idx +: 4];
      w_sub = r_y[4*r_idx +: 4];
    end
    // Range is -10..9, so bit 4 is the sign of the 5-bit two's-complement value.
    w_d     = {1'b0, w_min} - {1'b0, w_sub} - {4'd0, r_borrow};
    w_bout  = w_d[4];
    // Adding ten modulo 16 to the low nibble restores the decimal digit.
    w_digit = w_bout ? (w_d[3:0] + 4'd10) : w_d[3:0];
    w_r_next                  = r_r;
    w_r_next[4*r_idx +: 4]    = w_digit;
  end

  // --------------------------------------------------------------------------
  // Control and registered outputs. The edge that finishes the last digit
  // also loads z and raises done, so the done cycle is the DONE state cycle.
  // An invalid operand spends one DONE cycle waiting, then raises done.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_r        <= '0;
      r_idx      <= '0;
      r_borrow   <= 1'b0;
      r_err_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_z        <= '0;
      r_neg      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x <= x;
            r_y <= y;
            if (w_bad) begin
              r_state    <= S_DONE;
              r_err_pend <= 1'b1;
            end else begin
              r_state  <= S_SUB;
              r_busy   <= 1'b1;
              r_idx    <= '0;
              r_borrow <= b_in;
              r_r      <= '0;
            end
          end
        end

        S_SUB: begin
          r_r      <= w_r_next;
          r_borrow <= w_bout;
          if (r_idx == c_LAST) begin
            r_idx <= '0;
            if (w_bout) begin
              // Raw difference is negative: complement it in a second pass.
              r_state  <= S_FIX;
              r_borrow <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_z     <= w_r_next;
              r_neg   <= 1'b0;
              r_err   <= 1'b0;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_FIX: begin
          r_r      <= w_r_next;
          r_borrow <= w_bout;
          if (r_idx == c_LAST) begin
            r_idx   <= '0;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_z     <= w_r_next;
            r_neg   <= 1'b1;
            r_err   <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_DONE: begin
          if (r_err_pend) begin
            // Stay one more cycle so the done pulse still falls in DONE.
            r_err_pend <= 1'b0;
            r_done     <= 1'b1;
            r_z        <= '0;
            r_neg      <= 1'b0;
            r_err      <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign z    = r_z;
  assign neg  = r_neg;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_sub_serial
//  Purpose  : Self-checking bench for bcd_sub_serial (DIGITS = 4). Expected
//             results come from an integer model of x - y - b_in.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_sub_serial;

  localparam int c_D = 4;
  localparam int c_W = 4 * c_D;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [c_W-1:0] x;
  logic [c_W-1:0] y;
  logic           b_in;
  logic           busy;
  logic           done;
  logic [c_W-1:0] z;
  logic           neg;
  logic           err;

  int n_cmp = 0;
  int n_err = 0;

  bcd_sub_serial #(.DIGITS(c_D)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .neg   (neg),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [c_W-1:0] v);
    int acc = 0;
    for (int i = c_D - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic logic [c_W-1:0] int2bcd(input int v);
    logic [c_W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < c_D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [c_W-1:0] v);
    for (int i = 0; i < c_D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one operation and compare every observable against the model.
  task automatic do_op(input logic [c_W-1:0] xv, input logic [c_W-1:0] yv,
                       input logic bv, input string tag);
    int             diff, mag, lat, exp_lat;
    bit             bad, busy_ok;
    logic [c_W-1:0] exp_z;
    logic           exp_neg;
    bad  = has_bad(xv) || has_bad(yv);
    diff = bcd2int(xv) - bcd2int(yv) - int'(bv);
    mag  = (diff < 0) ? -diff : diff;
    mag  = mag % 10000;
    exp_z   = bad ? '0 : int2bcd(mag);
    exp_neg = bad ? 1'b0 : (diff < 0);
    exp_lat = bad ? 1 : ((diff < 0) ? 2 * c_D : c_D);

    @(negedge clk);
    x = xv; y = yv; b_in = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy !== !bad) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " z"}, 64'(z), 64'(exp_z));
    check({tag, " neg"}, 64'(neg), 64'(exp_neg));
    check({tag, " err"}, 64'(err), 64'(bad));
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    @(posedge clk); #1;
    check({tag, " pulse"}, 64'(done), 64'd0);
    check({tag, " hold z"}, 64'(z), 64'(exp_z));
  endtask

  initial begin
    int             nd, at;
    logic [c_W-1:0] rx, ry;

    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset z", 64'(z), 64'd0);
    check("reset neg", 64'(neg), 64'd0);
    check("reset err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h5000, 16'h1234, 1'b0, "pos");
    do_op(16'h1234, 16'h5000, 1'b0, "negres");
    do_op(16'h0000, 16'h0000, 1'b1, "bin");
    do_op(16'h9999, 16'h9999, 1'b0, "zero");
    do_op(16'h12A4, 16'h0001, 1'b0, "badx");
    do_op(16'h0001, 16'hF000, 1'b1, "bady");
    do_op(16'h9999, 16'h0000, 1'b1, "max");

    // A start during an operation must be dropped, not queued.
    @(negedge clk);
    x = 16'h1234; y = 16'h5000; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; at = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin x = 16'h0009; y = 16'h0001; end
      @(posedge clk); #1;
      if (done) begin nd++; at = k; end
      if (k == 3) start = 1'b0;
    end
    check("ignore count", 64'(nd), 64'd1);
    check("ignore at", 64'(at), 64'd8);
    check("ignore z", 64'(z), 64'h3766);
    check("ignore neg", 64'(neg), 64'd1);

    // Reset in the middle of an operation.
    @(negedge clk);
    x = 16'h1234; y = 16'h5000; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort z", 64'(z), 64'd0);
    check("abort neg", 64'(neg), 64'd0);
    check("abort err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort nodone", 64'(nd), 64'd0);
    do_op(16'h5000, 16'h1234, 1'b0, "restart");

    // Random operands; roughly one in eight carries an illegal digit.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < c_D; i++) begin
        rx[4*i +: 4] = 4'($urandom_range(0, 9));
        ry[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 5) == 0) ry = rx;
      if ($urandom_range(0, 7) == 0) rx[4*$urandom_range(0, c_D-1) +: 4] = 4'($urandom_range(10, 15));
      do_op(rx, ry, 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
